// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - CPU/DMA arbiter for the single data-memory port with bounded DMA bursts
// Optional stall-cycle statistics counter enabled by defining ARB_STATS_EN.
module mem_bus_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int BURST_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_we,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_we,
  output logic          dma_gnt,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   stall_cnt
);

  typedef enum logic [1:0] {
    CPU_OWN = 2'd0,
    DMA_OWN = 2'd1,
    YIELD   = 2'd2
  } state_e;

  localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);

  state_e        state_q, state_d;
  logic [7:0]    burst_cnt_q, burst_cnt_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;
  logic          dma_rvalid_q, dma_rvalid_d;
  logic          dma_own;

  assign dma_own = (state_q == DMA_OWN);

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      CPU_OWN: begin
        if (dma_req) begin
          state_d     = DMA_OWN;
          burst_cnt_d = 8'd0;
        end
      end
      DMA_OWN: begin
        if (!dma_req) begin
          state_d = CPU_OWN;
        end else if ((burst_cnt_q == BURST_LAST) && cpu_req) begin
          state_d = YIELD;
        end else if (burst_cnt_q != BURST_LAST) begin
          // Saturating here lets an idle CPU leave the DMA in charge indefinitely.
          burst_cnt_d = burst_cnt_q + 8'd1;
        end
      end
      YIELD: begin
        state_d     = dma_req ? DMA_OWN : CPU_OWN;
        burst_cnt_d = 8'd0;
      end
      default: begin
        state_d     = CPU_OWN;
        burst_cnt_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    mem_addr  = dma_own ? dma_addr  : cpu_addr;
    mem_wdata = dma_own ? dma_wdata : cpu_wdata;
    mem_we    = dma_own ? (dma_we & dma_req) : (cpu_we & cpu_req);
    dma_gnt   = dma_own & dma_req;
    cpu_stall = dma_own;
    cpu_rdata = mem_rdata;
  end

  always_comb begin
    dma_rdata_d  = dma_gnt ? mem_rdata : dma_rdata_q;
    dma_rvalid_d = dma_gnt;
  end

`ifdef ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cpu_stall && cpu_req && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= CPU_OWN;
      burst_cnt_q  <= 8'd0;
      dma_rdata_q  <= '0;
      dma_rvalid_q <= 1'b0;
`ifdef ARB_STATS_EN
      stall_cnt_q  <= 16'h0000;
`endif
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      dma_rdata_q  <= dma_rdata_d;
      dma_rvalid_q <= dma_rvalid_d;
`ifdef ARB_STATS_EN
      stall_cnt_q  <= stall_cnt_d;
`endif
    end
  end

  assign dma_rdata  = dma_rdata_q;
  assign dma_rvalid = dma_rvalid_q;

endmodule
